// File: rtl/mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx
//
// Memory-mapped 8N1 UART transmitter on the CPU data-memory bus. CPU stores to
// TXDATA push bytes into a circular FIFO; a serializer drains the FIFO onto
// the serial line. CPU loads return status and counters with one cycle of
// latency, and rd_hit tells the top level to mux rd_data onto the read path.
//
// Register map (word offsets from BASE_ADDR):
//   0 TXDATA  write pushes wr_data[7:0]; read returns 0
//   1 STATUS  {count[7:0], 5'b0, empty, full, busy}; read-only
//   2 DROPS   read returns drop_count; any write clears it
//   3 DIV     read returns CLKS_PER_BIT; read-only
//
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous active-high reset
//   rd_addr  read word address (bus bits [15:1])
//   rd_data  registered read data
//   rd_hit   registered; 1 when the previous cycle's rd_addr was in range
//   wr_en    write strobe
//   wr_addr  write word address
//   wr_data  write data
//   tx       registered serial output, idles high
//   tx_busy  registered; 1 while a frame is being shifted
// -----------------------------------------------------------------------------
module mmio_uart_tx #(
    parameter logic [14:0] BASE_ADDR    = 15'h7FF0,
    parameter logic [15:0] CLKS_PER_BIT = 16'd434,
    parameter int          FIFO_LOG2    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] rd_addr,
    output logic [15:0] rd_data,
    output logic        rd_hit,
    input  logic        wr_en,
    input  logic [14:0] wr_addr,
    input  logic [15:0] wr_data,
    output logic        tx,
    output logic        tx_busy
);

    localparam int                 DEPTH      = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0] FULL_COUNT = (FIFO_LOG2 + 1)'(DEPTH);
    localparam logic [15:0]        LAST_TICK  = CLKS_PER_BIT - 16'd1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // ------------------------------------------------------------------
    // Address decode. Subtracting the base first makes the range check a
    // single compare and keeps it correct for any BASE_ADDR.
    // ------------------------------------------------------------------
    logic [14:0] rd_off;
    logic [14:0] wr_off;
    logic        rd_in_range;
    logic        wr_in_range;
    logic        push_req;
    logic        drop_clr;

    assign rd_off      = rd_addr - BASE_ADDR;
    assign wr_off      = wr_addr - BASE_ADDR;
    assign rd_in_range = rd_off < 15'd4;
    assign wr_in_range = wr_off < 15'd4;
    assign push_req    = wr_en && wr_in_range && (wr_off[1:0] == 2'd0);
    assign drop_clr    = wr_en && wr_in_range && (wr_off[1:0] == 2'd2);

    // Upper write byte has no meaning in any register.
    logic unused_wr_hi;
    assign unused_wr_hi = ^wr_data[15:8];

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]           mem [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr;
    logic [FIFO_LOG2-1:0] rd_ptr;
    logic [FIFO_LOG2:0]   count;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 pop;
    logic                 push_ok;
    logic                 drop;
    logic [15:0]          drop_count;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_COUNT);
    // A full FIFO still accepts a push when the serializer pops that cycle.
    assign push_ok    = push_req && (!fifo_full || pop);
    assign drop       = push_req && fifo_full && !pop;

    // NOTE: storage has no reset; validity is tracked entirely by count and
    // the pointers, so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data[7:0];
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A clear wins over a simultaneous drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (drop_clr) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  idx_q,   idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        bit_done;

    assign bit_done = (timer_q == LAST_TICK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    timer_d = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    timer_d = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    timer_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    timer_d = '0;
                    // Chain straight into the next start bit when data waits.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line and busy are registered from the current state, so both lag the
    // state register by one cycle and the line never glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx      <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            tx_busy <= (state_q != IDLE);
            case (state_q)
                START:   tx <= 1'b0;
                DATA:    tx <= shift_q[idx_q];
                default: tx <= 1'b1;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------
    logic [15:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (rd_off[1:0])
            2'd1:    rd_mux = {8'(count), 5'b0, fifo_empty, fifo_full, tx_busy};
            2'd2:    rd_mux = drop_count;
            2'd3:    rd_mux = CLKS_PER_BIT;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_hit  <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_hit  <= rd_in_range;
            rd_data <= rd_in_range ? rd_mux : 16'h0000;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_mmio_uart_tx
//
// Directed sequence with random payload bytes. Every negedge the serial line
// and busy flag are logged; expected waveforms are derived from the bytes as
// 8N1 frames (start 0, data LSB first, stop 1), each level CPB cycles long.
// -----------------------------------------------------------------------------
module tb_mmio_uart_tx;

    localparam logic [14:0] BASE  = 15'h7FF0;
    localparam int          CPB   = 4;
    localparam int          LOG2  = 2;
    localparam int          DEPTH = 4;
    localparam int          FRAME = 10 * CPB;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [14:0] rd_addr = '0;
    logic [15:0] rd_data;
    logic        rd_hit;
    logic        wr_en = 1'b0;
    logic [14:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        tx;
    logic        tx_busy;

    int checks   = 0;
    int failures = 0;

    logic tx_hist[$];
    logic busy_hist[$];

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(16'(CPB)),
        .FIFO_LOG2   (LOG2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_hit (rd_hit),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .tx     (tx),
        .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: wait for the falling edge and log the line.
    task automatic tick();
        @(negedge clk);
        tx_hist.push_back(tx);
        busy_hist.push_back(tx_busy);
    endtask

    task automatic wait_until(input int n);
        while (tx_hist.size() < n) tick();
    endtask

    // Returns the log index of the sample taken just after the write edge.
    task automatic wr(input logic [14:0] a, input logic [15:0] d, output int idx);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        idx     = tx_hist.size() - 1;
    endtask

    task automatic rd(input string tag, input logic [14:0] a,
                      input logic exp_hit, input logic [15:0] exp_data);
        rd_addr = a;
        tick();
        check({tag, "_hit"}, 32'(rd_hit), 32'(exp_hit));
        check({tag, "_data"}, 32'(rd_data), 32'(exp_data));
        rd_addr = '0;
    endtask

    // Reference: bit k of an 8N1 frame.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    function automatic logic [15:0] status_word(input logic busy, input int cnt);
        return {8'(cnt), 5'b0, (cnt == 0), (cnt == DEPTH), busy};
    endfunction

    task automatic check_frames(input string tag, input int start, input byte_q_t bytes);
        for (int f = 0; f < bytes.size(); f++) begin
            for (int c = 0; c < FRAME; c++) begin
                check($sformatf("%s_f%0d_c%0d", tag, f, c),
                      32'(tx_hist[start + f*FRAME + c]),
                      32'(frame_bit(bytes[f], c / CPB)));
            end
        end
    endtask

    initial begin
        int      w;
        int      w2;
        int      r;
        int      lows;
        int      n_wr;
        byte_q_t q;
        logic [7:0] b;

        // ---------------- reset ----------------
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_hit", 32'(rd_hit), 32'd0);
        check("rst_data", 32'(rd_data), 32'd0);
        rd("rst_rd0", BASE + 15'd0, 1'b1, 16'h0000);
        rd("rst_rd1", BASE + 15'd1, 1'b1, 16'h0004);
        rd("rst_rd2", BASE + 15'd2, 1'b1, 16'h0000);
        rd("rst_rd3", BASE + 15'd3, 1'b1, 16'(CPB));

        // ---------------- single frames: 0x55 then random ----------------
        for (int t = 0; t < 2; t++) begin
            b = (t == 0) ? 8'h55 : 8'($urandom);
            tick();
            wr(BASE, {8'($urandom), b}, w);
            wait_until(w + 44);
            check("single_pre_tx", 32'(tx_hist[w+1]), 32'd1);
            check("single_pre_busy", 32'(busy_hist[w+1]), 32'd0);
            check("single_busy_on", 32'(busy_hist[w+2]), 32'd1);
            q = {};
            q.push_back(b);
            check_frames($sformatf("single%0d", t), w + 2, q);
            check("single_busy_last", 32'(busy_hist[w+41]), 32'd1);
            check("single_busy_off", 32'(busy_hist[w+42]), 32'd0);
            check("single_idle_tx", 32'(tx_hist[w+42]), 32'd1);
        end

        // ---------------- back-to-back: 01/80 then random pair ----------------
        for (int t = 0; t < 2; t++) begin
            q = {};
            q.push_back((t == 0) ? 8'h01 : 8'($urandom));
            q.push_back((t == 0) ? 8'h80 : 8'($urandom));
            tick();
            wr(BASE, {8'h00, q[0]}, w);
            wr(BASE, {8'h00, q[1]}, w2);
            wait_until(w + 2 + 2*FRAME + 2);
            check_frames($sformatf("b2b%0d", t), w + 2, q);
            check("b2b_busy_last", 32'(busy_hist[w + 1 + 2*FRAME]), 32'd1);
            check("b2b_busy_off", 32'(busy_hist[w + 2 + 2*FRAME]), 32'd0);
        end

        // ---------------- overflow ----------------
        n_wr = DEPTH + 2;
        q = {};
        tick();
        for (int i = 0; i < n_wr; i++) begin
            q.push_back(8'($urandom));
            wr(BASE, {8'($urandom), q[i]}, w2);
            if (i == 0) w = w2;
        end
        // First byte went to the shifter; the next DEPTH fill the FIFO.
        rd("ovf_status", BASE + 15'd1, 1'b1, status_word(1'b1, DEPTH));
        rd("ovf_drops", BASE + 15'd2, 1'b1, 16'(n_wr - 1 - DEPTH));
        wr(BASE + 15'd2, 16'($urandom), w2);
        rd("ovf_drops_clr", BASE + 15'd2, 1'b1, 16'h0000);
        wait_until(w + 2 + (DEPTH + 1)*FRAME + 4);
        void'(q.pop_back());  // last byte was dropped
        check_frames("ovf", w + 2, q);
        check("ovf_idle_tx", 32'(tx_hist[w + 2 + (DEPTH + 1)*FRAME + 1]), 32'd1);
        rd("ovf_status_end", BASE + 15'd1, 1'b1, 16'h0004);

        // ---------------- address decode ----------------
        tick();
        wr(BASE + 15'd4, 16'($urandom), w);
        wr(BASE - 15'd1, 16'($urandom), w2);
        for (int i = 0; i < 6; i++) tick();
        lows = 0;
        for (int i = w; i < tx_hist.size(); i++) if (tx_hist[i] !== 1'b1) lows++;
        check("dec_no_frame", 32'(lows), 32'd0);
        rd("dec_status", BASE + 15'd1, 1'b1, 16'h0004);
        rd("dec_rd_above", BASE + 15'd4, 1'b0, 16'h0000);
        rd("dec_rd_below", BASE - 15'd1, 1'b0, 16'h0000);

        // ---------------- reset mid-frame ----------------
        q = {};
        for (int i = 0; i < 3; i++) begin
            q.push_back(8'($urandom));
            wr(BASE, {8'h00, q[i]}, w2);
            if (i == 0) w = w2;
        end
        wait_until(w + 2 + 10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        r = tx_hist.size() - 1;
        check("mid_rst_tx", 32'(tx_hist[r]), 32'd1);
        check("mid_rst_busy", 32'(busy_hist[r]), 32'd0);
        for (int c = 0; c < 10; c++) begin
            check($sformatf("mid_pre_c%0d", c), 32'(tx_hist[w + 2 + c]),
                  32'(frame_bit(q[0], c / CPB)));
        end
        rd("mid_status", BASE + 15'd1, 1'b1, 16'h0004);
        for (int i = 0; i < 3*FRAME; i++) tick();
        lows = 0;
        for (int i = r; i < tx_hist.size(); i++) begin
            if (tx_hist[i] !== 1'b1 || busy_hist[i] !== 1'b0) lows++;
        end
        check("mid_no_more_frames", 32'(lows), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
